// File: rtl/fb_pkg.sv
// Shared types and helpers for the framebuffer draw sink.
package fb_pkg;

    // Width of the written/clipped statistics counters.
    localparam int CNT_W = 16;

    // Draw-sink controller states.
    typedef enum logic [1:0] {
        ST_READY,
        ST_DRAIN,
        ST_CLEAR,
        ST_DONE
    } state_t;

    // Address width needed to index every pixel of the framebuffer.
    function automatic int fb_addrw(input int pixels);
        return (pixels > 1) ? $clog2(pixels) : 1;
    endfunction

endpackage

// File: rtl/fb_coord_addr.sv
// Two-stage pixel pipeline: stage 1 registers the clip result, coordinates
// and colour; stage 2 registers the linear framebuffer address y*W + x.
module fb_coord_addr #(
    parameter int CORDW     = 16,
    parameter int COLRW     = 4,
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 180,
    parameter int ADDRW     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic signed [CORDW-1:0] i_x,
    input  logic signed [CORDW-1:0] i_y,
    input  logic        [COLRW-1:0] i_colr,
    output logic                    o_s1_valid,
    output logic                    o_s1_inb,
    output logic                    o_s2_valid,
    output logic        [ADDRW-1:0] o_addr,
    output logic        [COLRW-1:0] o_colr
);

    localparam logic signed [CORDW-1:0] X_LIM = CORDW'(FB_WIDTH);
    localparam logic signed [CORDW-1:0] Y_LIM = CORDW'(FB_HEIGHT);

    logic                    r_s1_valid;
    logic                    r_s1_inb;
    logic signed [CORDW-1:0] r_s1_x;
    logic signed [CORDW-1:0] r_s1_y;
    logic        [COLRW-1:0] r_s1_colr;
    logic                    r_s2_valid;
    logic        [ADDRW-1:0] r_s2_addr;
    logic        [COLRW-1:0] r_s2_colr;
    logic                    w_inb;
    logic        [ADDRW-1:0] w_addr;

    // Signed clip: a set sign bit means a negative coordinate.
    assign w_inb = !i_x[CORDW-1] && (i_x < X_LIM) &&
                   !i_y[CORDW-1] && (i_y < Y_LIM);

    // Only clipped-in coordinates reach stage 2, so the product never wraps.
    assign w_addr = ADDRW'(unsigned'(r_s1_y)) * ADDRW'(FB_WIDTH)
                  + ADDRW'(unsigned'(r_s1_x));

    // Stage 1 control: valid and in-bounds flags.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_inb   <= 1'b0;
        end else begin
            r_s1_valid <= i_valid;
            r_s1_inb   <= i_valid && w_inb;
        end
    end

    // Stage 1 data: coordinates and colour.
    always_ff @(posedge clk) begin
        // NOTE: payload registers carry no reset; they are qualified by
        // r_s1_valid, so their contents after reset are never used.
        r_s1_x    <= i_x;
        r_s1_y    <= i_y;
        r_s1_colr <= i_colr;
    end

    // Stage 2: linear address and colour for the framebuffer write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_colr  <= '0;
        end else begin
            r_s2_valid <= r_s1_inb;
            if (r_s1_inb) begin
                r_s2_addr <= w_addr;
                r_s2_colr <= r_s1_colr;
            end
        end
    end

    assign o_s1_valid = r_s1_valid;
    assign o_s1_inb   = r_s1_inb;
    assign o_s2_valid = r_s2_valid;
    assign o_addr     = r_s2_addr;
    assign o_colr     = r_s2_colr;

endmodule

// File: rtl/fb_draw_sink.sv
// Framebuffer draw sink: clips and writes renderer pixels, and runs a
// full-framebuffer clear on request while holding the renderer off via oe.
module fb_draw_sink
    import fb_pkg::*;
#(
    parameter int  CORDW     = 16,
    parameter int  COLRW     = 4,
    parameter int  FB_WIDTH  = 320,
    parameter int  FB_HEIGHT = 180,
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT,
    localparam int FB_ADDRW  = fb_addrw(FB_PIXELS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [CORDW-1:0] i_x,
    input  logic signed [CORDW-1:0] i_y,
    input  logic                    i_pix,
    input  logic                    i_drawing,
    input  logic        [COLRW-1:0] i_draw_colr,
    input  logic        [COLRW-1:0] i_clear_colr,
    input  logic                    i_clear,
    output logic                    o_oe,
    output logic                    o_busy,
    output logic                    o_clear_done,
    output logic                    o_fb_we,
    output logic     [FB_ADDRW-1:0] o_fb_addr,
    output logic        [COLRW-1:0] o_fb_colr,
    output logic        [CNT_W-1:0] o_cnt_written,
    output logic        [CNT_W-1:0] o_cnt_clipped
);

    localparam logic [FB_ADDRW-1:0] CLR_LAST = FB_ADDRW'(FB_PIXELS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_oe;
    logic [FB_ADDRW-1:0] r_clr_addr;
    logic [COLRW-1:0]    r_clear_colr;
    logic [CNT_W-1:0]    r_cnt_written;
    logic [CNT_W-1:0]    r_cnt_clipped;
    logic                w_accept;
    logic                w_clr_last;
    logic                w_clear_start;
    logic                w_s1_valid;
    logic                w_s1_inb;
    logic                w_s2_valid;
    logic [FB_ADDRW-1:0] w_s2_addr;
    logic [COLRW-1:0]    w_s2_colr;

    assign w_accept      = r_oe && i_drawing && i_pix;
    assign w_clr_last    = (r_clr_addr == CLR_LAST);
    assign w_clear_start = (r_state == ST_DRAIN) && (w_state_next == ST_CLEAR);

    fb_coord_addr #(
        .CORDW     (CORDW),
        .COLRW     (COLRW),
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT),
        .ADDRW     (FB_ADDRW)
    ) u_coord_addr (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (w_accept),
        .i_x        (i_x),
        .i_y        (i_y),
        .i_colr     (i_draw_colr),
        .o_s1_valid (w_s1_valid),
        .o_s1_inb   (w_s1_inb),
        .o_s2_valid (w_s2_valid),
        .o_addr     (w_s2_addr),
        .o_colr     (w_s2_colr)
    );

    // State register, plus oe registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_READY;
            r_oe    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_oe    <= (w_state_next == ST_READY);
        end
    end

    // Next-state logic. DRAIN ends once stage 1 is empty: any pixel left in
    // stage 2 writes in that last DRAIN cycle, before the clear starts.
    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch
        // is inferred.
        w_state_next = r_state;
        case (r_state)
            ST_READY: if (i_clear)     w_state_next = ST_DRAIN;
            ST_DRAIN: if (!w_s1_valid) w_state_next = ST_CLEAR;
            ST_CLEAR: if (w_clr_last)  w_state_next = ST_DONE;
            ST_DONE:                   w_state_next = ST_READY;
            default:                   w_state_next = ST_READY;
        endcase
    end

    // Write-port mux and status outputs: clear sweep in CLEAR, pipeline otherwise.
    always_comb begin
        o_fb_we      = w_s2_valid;
        o_fb_addr    = w_s2_addr;
        o_fb_colr    = w_s2_colr;
        o_busy       = (r_state != ST_READY);
        o_clear_done = (r_state == ST_DONE);
        if (r_state == ST_CLEAR) begin
            o_fb_we   = 1'b1;
            o_fb_addr = r_clr_addr;
            o_fb_colr = r_clear_colr;
        end
    end

    // Clear address sweep; sits at zero outside CLEAR so each sweep starts at 0.
    always_ff @(posedge clk) begin
        if (rst || r_state != ST_CLEAR || w_clr_last) begin
            r_clr_addr <= '0;
        end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
        end
    end

    // Latch the clear colour when a clear request is taken in READY.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clear_colr <= '0;
        end else if (r_state == ST_READY && i_clear) begin
            r_clear_colr <= i_clear_colr;
        end
    end

    // Saturating statistics counters, driven by the stage 1 clip result.
    always_ff @(posedge clk) begin
        if (rst || w_clear_start) begin
            r_cnt_written <= '0;
            r_cnt_clipped <= '0;
        end else begin
            if (w_s1_inb && r_cnt_written != '1) begin
                r_cnt_written <= r_cnt_written + 1'b1;
            end
            if (w_s1_valid && !w_s1_inb && r_cnt_clipped != '1) begin
                r_cnt_clipped <= r_cnt_clipped + 1'b1;
            end
        end
    end

    assign o_oe          = r_oe;
    assign o_cnt_written = r_cnt_written;
    assign o_cnt_clipped = r_cnt_clipped;

endmodule
